// File: rtl/interact_ctrl_pkg.sv
// Shared definitions for the tile-interaction front end: direction codes,
// controller states, tile constants and map address packing.
package interact_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Tile id presented to the resolver when the target lies outside the map
  localparam logic [15:0] TILE_BLOCKED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_COMMIT
  } state_t;

  // Low byte of the map address; the floor bits are prepended by the caller
  function automatic logic [7:0] map_yx(input logic [3:0] y, input logic [3:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/interact_ctrl_move_target.sv
// Combinational neighbour computation: direction plus current position gives
// the target cell, or flags the move as leaving the map.
module move_target
  import interact_ctrl_pkg::*;
#(
  parameter int MAP_W = 13,
  parameter int MAP_H = 13
) (
  input  logic [1:0] dir,
  input  logic [3:0] pos_x,
  input  logic [3:0] pos_y,
  output logic [3:0] tgt_x,
  output logic [3:0] tgt_y,
  output logic       off_map
);

  localparam logic [3:0] X_MAX = 4'(MAP_W - 1);
  localparam logic [3:0] Y_MAX = 4'(MAP_H - 1);

  // An off-map target stays on the current cell so nothing downstream wraps
  always_comb begin
    tgt_x   = pos_x;
    tgt_y   = pos_y;
    off_map = 1'b0;
    case (dir)
      DIR_UP: begin
        if (pos_y == 4'd0) off_map = 1'b1;
        else               tgt_y   = pos_y - 4'd1;
      end
      DIR_DOWN: begin
        if (pos_y == Y_MAX) off_map = 1'b1;
        else                tgt_y   = pos_y + 4'd1;
      end
      DIR_LEFT: begin
        if (pos_x == 4'd0) off_map = 1'b1;
        else               tgt_x   = pos_x - 4'd1;
      end
      default: begin
        if (pos_x == X_MAX) off_map = 1'b1;
        else                tgt_x   = pos_x + 4'd1;
      end
    endcase
  end

endmodule

// File: rtl/interact_ctrl.sv
// Sequential front end of the tile-interaction path: read target tile, hand it
// to the resolver, commit results. Optional step counter: INTERACT_STEP_CNT_EN.
module interact_ctrl
  import interact_ctrl_pkg::*;
#(
  parameter int MAP_W       = 13,
  parameter int MAP_H       = 13,
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_BITS  = 4,
  parameter int INIT_X      = 6,
  parameter int INIT_Y      = 12,
  parameter int INIT_HEALTH = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  move_valid,
  input  logic [1:0]            move_dir,
  output logic                  move_ready,
  output logic                  map_rd_en,
  output logic [FLOOR_BITS+7:0] map_addr,
  input  logic [15:0]           map_rd_data,
  output logic                  map_wr_en,
  output logic [15:0]           map_wr_data,
  output logic [3:0]            res_pos_x,
  output logic [3:0]            res_pos_y,
  output logic [15:0]           res_tile_id,
  output logic [15:0]           res_floor_in,
  output logic [3:0]            res_player_x,
  output logic [3:0]            res_player_y,
  output logic [31:0]           res_key_num_in,
  output logic [15:0]           res_health_in,
  input  logic [15:0]           res_floor,
  input  logic [3:0]            res_goto_x,
  input  logic [3:0]            res_goto_y,
  input  logic [31:0]           res_key_num,
  input  logic [15:0]           res_health,
  input  logic [15:0]           res_new_tile_id,
  output logic [3:0]            player_x,
  output logic [3:0]            player_y,
  output logic [15:0]           floor,
  output logic [31:0]           key_num,
  output logic [15:0]           health,
  output logic                  done,
  output logic                  moved
`ifdef INTERACT_STEP_CNT_EN
  ,
  output logic [15:0]           step_cnt
`endif
);

  localparam logic [15:0] FLOOR_LIMIT = 16'(NUM_FLOORS);

  state_t state, state_next;

  logic [3:0]  tgt_x, tgt_y;
  logic        off_map_q;
  logic [15:0] tile_q;

  logic [3:0]  mt_tgt_x, mt_tgt_y;
  logic        mt_off_map;
  logic        accept;
  logic        floor_ok;
  logic        commit_ok;

  move_target #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_move_target (
    .dir     (move_dir),
    .pos_x   (player_x),
    .pos_y   (player_y),
    .tgt_x   (mt_tgt_x),
    .tgt_y   (mt_tgt_y),
    .off_map (mt_off_map)
  );

  assign accept    = move_valid && move_ready;
  assign floor_ok  = res_floor < FLOOR_LIMIT;
  assign commit_ok = (state == ST_COMMIT) && !off_map_q && floor_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Off-map requests skip the RAM round trip and go straight to commit
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (move_valid) state_next = mt_off_map ? ST_COMMIT : ST_READ;
      ST_READ:  state_next = ST_LATCH;
      ST_LATCH: state_next = ST_COMMIT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    move_ready  = (state == ST_IDLE);
    map_rd_en   = (state == ST_READ);
    done        = (state == ST_COMMIT);
    map_wr_en   = commit_ok && (res_new_tile_id != tile_q);
    map_wr_data = res_new_tile_id;
    map_addr    = {floor[FLOOR_BITS-1:0], map_yx(tgt_y, tgt_x)};
    moved       = commit_ok && ((res_goto_x != player_x) || (res_goto_y != player_y) ||
                                (res_floor != floor));
  end

  assign res_pos_x      = tgt_x;
  assign res_pos_y      = tgt_y;
  assign res_tile_id    = tile_q;
  assign res_floor_in   = floor;
  assign res_player_x   = player_x;
  assign res_player_y   = player_y;
  assign res_key_num_in = key_num;
  assign res_health_in  = health;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_x     <= 4'd0;
      tgt_y     <= 4'd0;
      off_map_q <= 1'b0;
      tile_q    <= 16'd0;
    end else if (accept) begin
      tgt_x     <= mt_tgt_x;
      tgt_y     <= mt_tgt_y;
      off_map_q <= mt_off_map;
      if (mt_off_map) tile_q <= TILE_BLOCKED;
    end else if (state == ST_LATCH) begin
      tile_q <= map_rd_data;
    end
  end

  // An out-of-range floor leaves position and floor alone but still takes keys/health
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_x <= 4'(INIT_X);
      player_y <= 4'(INIT_Y);
      floor    <= 16'd0;
      key_num  <= 32'd0;
      health   <= 16'(INIT_HEALTH);
    end else if ((state == ST_COMMIT) && !off_map_q) begin
      key_num <= res_key_num;
      health  <= res_health;
      if (floor_ok) begin
        player_x <= res_goto_x;
        player_y <= res_goto_y;
        floor    <= res_floor;
      end
    end
  end

`ifdef INTERACT_STEP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            step_cnt <= 16'd0;
    else if (moved && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_interact_ctrl.sv
// Directed self-checking bench for interact_ctrl with a behavioural map RAM and
// a configurable resolver. Step counter checks need INTERACT_STEP_CNT_EN.
module tb_interact_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        map_rd_en;
  logic [11:0] map_addr;
  logic [15:0] map_rd_data = 16'd0;
  logic        map_wr_en;
  logic [15:0] map_wr_data;
  logic [3:0]  res_pos_x, res_pos_y;
  logic [15:0] res_tile_id, res_floor_in;
  logic [3:0]  res_player_x, res_player_y;
  logic [31:0] res_key_num_in;
  logic [15:0] res_health_in;
  logic [15:0] res_floor;
  logic [3:0]  res_goto_x, res_goto_y;
  logic [31:0] res_key_num;
  logic [15:0] res_health, res_new_tile_id;
  logic [3:0]  player_x, player_y;
  logic [15:0] floor;
  logic [31:0] key_num;
  logic [15:0] health;
  logic        done, moved;
`ifdef INTERACT_STEP_CNT_EN
  logic [15:0] step_cnt;
`endif

  int tests = 0;
  int fails = 0;

  int          res_mode = 0;
  logic [3:0]  ovr_x = 4'd0, ovr_y = 4'd0;
  logic [15:0] stair_floor = 16'd0;
  logic [15:0] ram_tile = 16'h0001;

  int          cyc = 0;
  int          rd_count = 0, wr_count = 0, done_n = 0, acc_n = 0;
  logic [11:0] last_rd_addr = 12'd0, last_wr_addr = 12'd0;
  logic [15:0] last_wr_data = 16'd0;
  int          acc_cyc [8];
  logic        seen_done, seen_moved;
  int          snap;

  interact_ctrl dut (
    .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .map_rd_en(map_rd_en), .map_addr(map_addr),
    .map_rd_data(map_rd_data), .map_wr_en(map_wr_en), .map_wr_data(map_wr_data),
    .res_pos_x(res_pos_x), .res_pos_y(res_pos_y), .res_tile_id(res_tile_id),
    .res_floor_in(res_floor_in), .res_player_x(res_player_x), .res_player_y(res_player_y),
    .res_key_num_in(res_key_num_in), .res_health_in(res_health_in),
    .res_floor(res_floor), .res_goto_x(res_goto_x), .res_goto_y(res_goto_y),
    .res_key_num(res_key_num), .res_health(res_health), .res_new_tile_id(res_new_tile_id),
    .player_x(player_x), .player_y(player_y), .floor(floor), .key_num(key_num),
    .health(health), .done(done), .moved(moved)
`ifdef INTERACT_STEP_CNT_EN
    , .step_cnt(step_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Resolver stand-in: echo by default, with teleport, key pickup and stair modes
  always_comb begin
    res_floor       = res_floor_in;
    res_goto_x      = res_pos_x;
    res_goto_y      = res_pos_y;
    res_key_num     = res_key_num_in;
    res_health      = res_health_in;
    res_new_tile_id = res_tile_id;
    case (res_mode)
      1: begin res_goto_x = ovr_x; res_goto_y = ovr_y; end
      2: begin res_key_num = res_key_num_in + 32'd1; res_new_tile_id = 16'h0001; end
      3: begin
        res_floor = stair_floor; res_goto_x = res_player_x; res_goto_y = res_player_y;
        res_new_tile_id = 16'h0002;
      end
      default: ;
    endcase
  end

  // Map RAM model and event log
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (map_rd_en) begin
      map_rd_data <= ram_tile;
      rd_count = rd_count + 1;
      last_rd_addr = map_addr;
    end
    if (map_wr_en) begin
      wr_count = wr_count + 1;
      last_wr_addr = map_addr;
      last_wr_data = map_wr_data;
    end
    if (done) done_n = done_n + 1;
    if (rst_n && move_valid && move_ready && acc_n < 8) begin
      acc_cyc[acc_n] = cyc;
      acc_n = acc_n + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full four-cycle request; done/moved are captured in the commit cycle
  task automatic applyStimulus(input logic [1:0] dir);
    move_valid = 1'b1;
    move_dir   = dir;
    step();
    move_valid = 1'b0;
    step();
    step();
    seen_done  = done;
    seen_moved = moved;
    step();
  endtask

  initial begin
    rst_n      = 1'b1;
    move_valid = 1'b0;
    move_dir   = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready",  32'(move_ready), 32'd1);
    checkOutput("rst_px",     32'(player_x),   32'd6);
    checkOutput("rst_py",     32'(player_y),   32'd12);
    checkOutput("rst_floor",  32'(floor),      32'd0);
    checkOutput("rst_keys",   key_num,         32'd0);
    checkOutput("rst_health", 32'(health),     32'd100);
    checkOutput("rst_ctl",    {29'd0, done, map_rd_en, map_wr_en}, 32'd0);
    checkOutput("rst_tile",   32'(res_tile_id), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Right onto ground at (7,12)
    move_valid = 1'b1;
    move_dir   = 2'd3;
    step();
    move_valid = 1'b0;
    checkOutput("t1_rd_en",  32'(map_rd_en),  32'd1);
    checkOutput("t1_addr",   32'(map_addr),   32'h0C7);
    checkOutput("t1_ready",  32'(move_ready), 32'd0);
    step();
    checkOutput("t1_nodone", 32'(done), 32'd0);
    step();
    checkOutput("t1_done",   32'(done),      32'd1);
    checkOutput("t1_moved",  32'(moved),     32'd1);
    checkOutput("t1_nowr",   32'(map_wr_en), 32'd0);
    checkOutput("t1_tile",   32'(res_tile_id), 32'h0001);
    step();
    checkOutput("t1_px",     32'(player_x),  32'd7);
    checkOutput("t1_py",     32'(player_y),  32'd12);
    checkOutput("t1_ready2", 32'(move_ready), 32'd1);
    checkOutput("t1_health", 32'(health),    32'd100);

    // Down at the bottom edge: done one cycle after accept, no RAM access
    snap = rd_count;
    move_valid = 1'b1;
    move_dir   = 2'd1;
    step();
    move_valid = 1'b0;
    checkOutput("t2d_done",  32'(done),      32'd1);
    checkOutput("t2d_moved", 32'(moved),     32'd0);
    checkOutput("t2d_rd",    32'(map_rd_en), 32'd0);
    checkOutput("t2d_tile",  32'(res_tile_id), 32'hFFFF);
    step();
    checkOutput("t2d_py",    32'(player_y),  32'd12);
    checkOutput("t2d_rdcnt", rd_count - snap, 32'd0);

    // Resolver teleports to (7,0), then up at the top edge
    res_mode = 1; ovr_x = 4'd7; ovr_y = 4'd0;
    applyStimulus(2'd0);
    res_mode = 0;
    checkOutput("tp_py", 32'(player_y), 32'd0);
    snap = rd_count;
    move_valid = 1'b1;
    move_dir   = 2'd0;
    step();
    move_valid = 1'b0;
    checkOutput("t2u_done",  32'(done),  32'd1);
    checkOutput("t2u_moved", 32'(moved), 32'd0);
    step();
    checkOutput("t2u_pos",   {24'd0, player_x, player_y}, 32'h70);
    checkOutput("t2u_rdcnt", rd_count - snap, 32'd0);

    // Key pickup at (8,0): tile rewritten to ground
    ram_tile = 16'h0005; res_mode = 2; snap = wr_count;
    applyStimulus(2'd3);
    ram_tile = 16'h0001; res_mode = 0;
    checkOutput("t3_wrcnt",  wr_count - snap, 32'd1);
    checkOutput("t3_wraddr", 32'(last_wr_addr), 32'h008);
    checkOutput("t3_wrdata", 32'(last_wr_data), 32'h0001);
    checkOutput("t3_keys",   key_num,          32'd1);
    checkOutput("t3_px",     32'(player_x),    32'd8);

    // Stair past the top floor is blocked
    res_mode = 3; stair_floor = 16'd10; snap = wr_count;
    applyStimulus(2'd2);
    checkOutput("t4_done",  32'(seen_done),  32'd1);
    checkOutput("t4_moved", 32'(seen_moved), 32'd0);
    checkOutput("t4_floor", 32'(floor),      32'd0);
    checkOutput("t4_pos",   {24'd0, player_x, player_y}, 32'h80);
    checkOutput("t4_wrcnt", wr_count - snap, 32'd0);

    // Legal stair: floor changes, write lands on the old floor
    stair_floor = 16'd1; snap = wr_count;
    applyStimulus(2'd2);
    res_mode = 0;
    checkOutput("t4b_moved",  32'(seen_moved), 32'd1);
    checkOutput("t4b_floor",  32'(floor),      32'd1);
    checkOutput("t4b_px",     32'(player_x),   32'd8);
    checkOutput("t4b_wrcnt",  wr_count - snap, 32'd1);
    checkOutput("t4b_wraddr", 32'(last_wr_addr), 32'h007);
    applyStimulus(2'd1);
    checkOutput("t4c_rdaddr", 32'(last_rd_addr), 32'h118);
    checkOutput("t4c_py",     32'(player_y),     32'd1);

    // Reset during LATCH
    snap = wr_count;
    move_valid = 1'b1;
    move_dir   = 2'd3;
    step();
    move_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("t5_ready", 32'(move_ready), 32'd1);
    checkOutput("t5_ctl",   {29'd0, done, map_rd_en, map_wr_en}, 32'd0);
    checkOutput("t5_pos",   {24'd0, player_x, player_y}, 32'h6C);
    checkOutput("t5_floor", 32'(floor),      32'd0);
    checkOutput("t5_keys",  key_num,         32'd0);
    checkOutput("t5_tile",  32'(res_tile_id), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("t5_wrcnt",  wr_count - snap, 32'd0);
    checkOutput("t5_ready2", 32'(move_ready), 32'd1);
`ifdef INTERACT_STEP_CNT_EN
    checkOutput("t6_cnt0", 32'(step_cnt), 32'd0);
`endif

    // Auto-repeat with move_valid held
    acc_n = 0; done_n = 0;
    move_valid = 1'b1;
    move_dir   = 2'd3;
    for (int i = 0; i < 9; i++) step();
    move_valid = 1'b0;
    for (int i = 0; i < 10 && !move_ready; i++) step();
    checkOutput("t6_idle",   32'(move_ready), 32'd1);
    checkOutput("t6_acc",    acc_n,  32'd3);
    checkOutput("t6_done",   done_n, 32'd3);
    checkOutput("t6_gap1",   acc_cyc[1] - acc_cyc[0], 32'd4);
    checkOutput("t6_gap2",   acc_cyc[2] - acc_cyc[0], 32'd8);
    checkOutput("t6_px",     32'(player_x), 32'd9);
`ifdef INTERACT_STEP_CNT_EN
    checkOutput("t6_cnt3", 32'(step_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
